// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle controller: stage encodings, opcode constants
// and the decoded-opcode record.
package cpu_pkg;

    localparam int unsigned STAGE_W = 3;
    localparam int unsigned OP_W    = 6;

    typedef enum logic [STAGE_W-1:0] {
        StIfetch    = 3'd0,
        StDecode    = 3'd1,
        StExecute   = 3'd2,
        StMemory    = 3'd3,
        StWriteback = 3'd4,
        StTrap      = 3'd5,
        StHalted    = 3'd6
    } stage_e;

    localparam logic [OP_W-1:0] OP_ADD  = 6'h00;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'h04;
    localparam logic [OP_W-1:0] OP_LW   = 6'h23;
    localparam logic [OP_W-1:0] OP_SW   = 6'h2B;
    localparam logic [OP_W-1:0] OP_HALT = 6'h3F;

    typedef struct packed {
        logic is_add;
        logic is_beq;
        logic is_lw;
        logic is_sw;
        logic is_halt;
        logic illegal;
    } dec_t;

    // Stages that sit in a handshake and may wait on an ack.
    function automatic logic is_wait_stage(stage_e s);
        return (s == StIfetch) || (s == StMemory);
    endfunction

endpackage

// File: rtl/op_decode.sv
// Combinational opcode decoder: one flag per supported instruction plus an illegal flag
// covering every other encoding.
module op_decode
    import cpu_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    output dec_t                o_dec
);

    logic w_add;
    logic w_beq;
    logic w_lw;
    logic w_sw;
    logic w_halt;

    always_comb begin
        w_add  = (i_opcode == OPCODE_W'(OP_ADD));
        w_beq  = (i_opcode == OPCODE_W'(OP_BEQ));
        w_lw   = (i_opcode == OPCODE_W'(OP_LW));
        w_sw   = (i_opcode == OPCODE_W'(OP_SW));
        w_halt = (i_opcode == OPCODE_W'(OP_HALT));
    end

    always_comb begin
        o_dec         = '0;
        o_dec.is_add  = w_add;
        o_dec.is_beq  = w_beq;
        o_dec.is_lw   = w_lw;
        o_dec.is_sw   = w_sw;
        o_dec.is_halt = w_halt;
        o_dec.illegal = ~(w_add | w_beq | w_lw | w_sw | w_halt);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: fetch/decode/execute/memory/writeback sequencing with
// sticky trap and halt states. Optional performance counters under `PERF_CNT_EN`.
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] instr,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ack,
    output logic [INSTR_W-1:0] ir,
    output logic [2:0]         stage,
    output logic               pc_we,
    output logic               rf_we,
    output logic               br_eval,
    output logic               retire,
    output logic               trap,
    output logic               halted,
    output logic [CNT_W-1:0]   retire_cnt,
    output logic [CNT_W-1:0]   stall_cnt
);

    stage_e               r_state;
    stage_e               w_next;
    logic [INSTR_W-1:0]   r_ir;
    dec_t                 w_dec;

    logic w_imem_req;
    logic w_dmem_req;
    logic w_dmem_we;
    logic w_pc_we;
    logic w_rf_we;
    logic w_br_eval;
    logic w_retire;
    logic w_trap;
    logic w_halted;

    op_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_op_decode (
        .i_opcode (r_ir[INSTR_W-1 -: OPCODE_W]),
        .o_dec    (w_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIfetch;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir <= '0;
        end else if (r_state == StIfetch && imem_ack) begin
            r_ir <= instr;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            StIfetch: begin
                if (imem_ack) begin
                    w_next = StDecode;
                end
            end
            StDecode: begin
                if (w_dec.illegal) begin
                    w_next = StTrap;
                end else if (w_dec.is_halt) begin
                    w_next = StHalted;
                end else begin
                    w_next = StExecute;
                end
            end
            StExecute: begin
                if (w_dec.is_add) begin
                    w_next = StWriteback;
                end else if (w_dec.is_lw || w_dec.is_sw) begin
                    w_next = StMemory;
                end else begin
                    w_next = StIfetch;
                end
            end
            StMemory: begin
                if (dmem_ack) begin
                    w_next = w_dec.is_lw ? StWriteback : StIfetch;
                end
            end
            StWriteback: w_next = StIfetch;
            StTrap:      w_next = StTrap;
            StHalted:    w_next = StHalted;
            default:     w_next = StIfetch;
        endcase
    end

    always_comb begin
        w_imem_req = 1'b0;
        w_dmem_req = 1'b0;
        w_dmem_we  = 1'b0;
        w_pc_we    = 1'b0;
        w_rf_we    = 1'b0;
        w_br_eval  = 1'b0;
        w_retire   = 1'b0;
        w_trap     = 1'b0;
        w_halted   = 1'b0;
        case (r_state)
            StIfetch: begin
                w_imem_req = 1'b1;
                w_pc_we    = imem_ack;
            end
            StExecute: begin
                w_br_eval = w_dec.is_beq;
                w_retire  = w_dec.is_beq;
            end
            StMemory: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = w_dec.is_sw;
                w_retire   = w_dec.is_sw & dmem_ack;
            end
            StWriteback: begin
                w_rf_we  = 1'b1;
                w_retire = 1'b1;
            end
            StTrap:   w_trap   = 1'b1;
            StHalted: w_halted = 1'b1;
            default: ;
        endcase
    end

    // Reset must silence outputs immediately, not at the next edge.
    assign imem_req = w_imem_req & rst_n;
    assign dmem_req = w_dmem_req & rst_n;
    assign dmem_we  = w_dmem_we  & rst_n;
    assign pc_we    = w_pc_we    & rst_n;
    assign rf_we    = w_rf_we    & rst_n;
    assign br_eval  = w_br_eval  & rst_n;
    assign retire   = w_retire   & rst_n;
    assign trap     = w_trap     & rst_n;
    assign halted   = w_halted   & rst_n;
    assign stage    = r_state;
    assign ir       = r_ir;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] r_retire_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_stall;

    always_comb begin
        w_stall = 1'b0;
        if (is_wait_stage(r_state)) begin
            w_stall = (r_state == StIfetch) ? ~imem_ack : ~dmem_ack;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_retire && r_retire_cnt != '1) begin
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
            if (w_stall && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign retire_cnt = r_retire_cnt;
    assign stall_cnt  = r_stall_cnt;
`else
    assign retire_cnt = '0;
    assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; counter expectations follow PERF_CNT_EN.
module tb_multicycle_ctrl;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned CNT_W    = 32;
`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [8:0] S_IREQ = 9'h100;
    localparam logic [8:0] S_PCWE = 9'h080;
    localparam logic [8:0] S_DREQ = 9'h040;
    localparam logic [8:0] S_DWE  = 9'h020;
    localparam logic [8:0] S_RFWE = 9'h010;
    localparam logic [8:0] S_BR   = 9'h008;
    localparam logic [8:0] S_RET  = 9'h004;
    localparam logic [8:0] S_TRAP = 9'h002;
    localparam logic [8:0] S_HALT = 9'h001;

    localparam logic [31:0] I_ADD  = 32'h0000_1234;
    localparam logic [31:0] I_BEQ  = 32'h1000_0000;
    localparam logic [31:0] I_LW   = 32'h8C00_0000;
    localparam logic [31:0] I_SW   = 32'hAC00_0000;
    localparam logic [31:0] I_HALT = 32'hFC00_0000;
    localparam logic [31:0] I_ILL  = 32'h0400_0000;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               imem_ack = 1'b0;
    logic               dmem_ack = 1'b0;
    logic [INSTR_W-1:0] instr = '0;
    logic               imem_req, dmem_req, dmem_we, pc_we, rf_we, br_eval, retire, trap, halted;
    logic [INSTR_W-1:0] ir;
    logic [2:0]         stage;
    logic [CNT_W-1:0]   retire_cnt, stall_cnt;
    logic [8:0]         strb;

    int n_checks = 0;
    int n_fail   = 0;

    assign strb = {imem_req, pc_we, dmem_req, dmem_we, rf_we, br_eval, retire, trap, halted};

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .INSTR_W  (INSTR_W),
        .OPCODE_W (OPCODE_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .instr      (instr),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .ir         (ir),
        .stage      (stage),
        .pc_we      (pc_we),
        .rf_we      (rf_we),
        .br_eval    (br_eval),
        .retire     (retire),
        .trap       (trap),
        .halted     (halted),
        .retire_cnt (retire_cnt),
        .stall_cnt  (stall_cnt)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        imem_ack = 1'b1;
        rst_n    = 1'b1;
    endtask

    task automatic test_reset();
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        instr    = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (stage !== 3'd0) begin
            n_fail++; $display("FAIL reset_stage: got %0d want 0", stage);
        end
        n_checks++;
        if (ir !== 32'h0) begin
            n_fail++; $display("FAIL reset_ir: got %h want 0", ir);
        end
        n_checks++;
        if (strb !== 9'h0) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 0", strb);
        end
        n_checks++;
        if (retire_cnt !== '0 || stall_cnt !== '0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", retire_cnt, stall_cnt);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (strb !== 9'h0 || ir !== 32'h0) begin
            n_fail++; $display("FAIL reset_held: strobes %b ir %h want 0", strb, ir);
        end
        @(posedge clk);
        #1;
        instr = I_ADD;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (strb !== (S_IREQ | S_PCWE)) begin
            n_fail++; $display("FAIL reset_release_req: got %b want %b", strb, S_IREQ | S_PCWE);
        end
    endtask

    task automatic test_add();
        logic [2:0] exp_stage [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
        logic [8:0] exp_strb  [4] = '{S_IREQ | S_PCWE, 9'h0, 9'h0, S_RFWE | S_RET};
        instr = I_ADD;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++;
            if (stage !== exp_stage[c]) begin
                n_fail++; $display("FAIL add_stage c%0d: got %0d want %0d", c, stage, exp_stage[c]);
            end
            n_checks++;
            if (strb !== exp_strb[c]) begin
                n_fail++; $display("FAIL add_strobes c%0d: got %b want %b", c, strb, exp_strb[c]);
            end
            @(posedge clk);
            #1;
            if (c == 0) instr = I_HALT;
        end
        n_checks++;
        if (ir !== I_ADD) begin
            n_fail++; $display("FAIL add_ir_hold: got %h want %h", ir, I_ADD);
        end
    endtask

    task automatic test_lw();
        logic [2:0] exp_stage [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        logic [8:0] exp_strb  [8] = '{S_IREQ | S_PCWE, 9'h0, 9'h0, S_DREQ, S_DREQ, S_DREQ,
                                      S_DREQ, S_RFWE | S_RET};
        logic       dack      [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [CNT_W-1:0] exp_stall;
        logic [CNT_W-1:0] exp_ret;
        instr    = I_LW;
        imem_ack = 1'b1;
        for (int c = 0; c < 8; c++) begin
            dmem_ack = dack[c];
            #1;
            n_checks++;
            if (stage !== exp_stage[c]) begin
                n_fail++; $display("FAIL lw_stage c%0d: got %0d want %0d", c, stage, exp_stage[c]);
            end
            n_checks++;
            if (strb !== exp_strb[c]) begin
                n_fail++; $display("FAIL lw_strobes c%0d: got %b want %b", c, strb, exp_strb[c]);
            end
            @(posedge clk);
            #1;
        end
        exp_stall = PERF ? 32'd3 : 32'd0;
        exp_ret   = PERF ? 32'd2 : 32'd0;
        n_checks++;
        if (stall_cnt !== exp_stall) begin
            n_fail++; $display("FAIL lw_stall_cnt: got %0d want %0d", stall_cnt, exp_stall);
        end
        n_checks++;
        if (retire_cnt !== exp_ret) begin
            n_fail++; $display("FAIL lw_retire_cnt: got %0d want %0d", retire_cnt, exp_ret);
        end
    endtask

    task automatic test_sw_beq();
        logic [31:0] ipat     [7] = '{I_SW, I_SW, I_SW, I_SW, I_BEQ, I_BEQ, I_BEQ};
        logic [2:0] exp_stage [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2};
        logic [8:0] exp_strb  [7] = '{S_IREQ | S_PCWE, 9'h0, 9'h0, S_DREQ | S_DWE | S_RET,
                                      S_IREQ | S_PCWE, 9'h0, S_BR | S_RET};
        logic [CNT_W-1:0] exp_ret;
        instr    = I_SW;
        dmem_ack = 1'b1;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            instr = ipat[c];
            #1;
            n_checks++;
            if (stage !== exp_stage[c]) begin
                n_fail++; $display("FAIL swbeq_stage c%0d: got %0d want %0d", c, stage, exp_stage[c]);
            end
            n_checks++;
            if (strb !== exp_strb[c]) begin
                n_fail++; $display("FAIL swbeq_strobes c%0d: got %b want %b", c, strb, exp_strb[c]);
            end
            @(posedge clk);
            #1;
        end
        exp_ret = PERF ? 32'd2 : 32'd0;
        n_checks++;
        if (retire_cnt !== exp_ret) begin
            n_fail++; $display("FAIL swbeq_retire_cnt: got %0d want %0d", retire_cnt, exp_ret);
        end
        n_checks++;
        if (stall_cnt !== '0) begin
            n_fail++; $display("FAIL swbeq_stall_cnt: got %0d want 0", stall_cnt);
        end
    endtask

    task automatic test_trap();
        logic [2:0] exp_stage;
        logic [8:0] exp_strb;
        instr    = I_ILL;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        for (int c = 0; c < 12; c++) begin
            exp_stage = (c == 0) ? 3'd0 : (c == 1) ? 3'd1 : 3'd5;
            exp_strb  = (c == 0) ? (S_IREQ | S_PCWE) : (c == 1) ? 9'h0 : S_TRAP;
            #1;
            n_checks++;
            if (stage !== exp_stage) begin
                n_fail++; $display("FAIL trap_stage c%0d: got %0d want %0d", c, stage, exp_stage);
            end
            n_checks++;
            if (strb !== exp_strb) begin
                n_fail++; $display("FAIL trap_strobes c%0d: got %b want %b", c, strb, exp_strb);
            end
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (stage !== 3'd0 || strb !== 9'h0) begin
            n_fail++; $display("FAIL trap_reset_clear: stage %0d strobes %b want 0/0", stage, strb);
        end
        n_checks++;
        if (ir !== 32'h0) begin
            n_fail++; $display("FAIL trap_reset_ir: got %h want 0", ir);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_mem();
        logic [2:0] exp_stage [3] = '{3'd0, 3'd1, 3'd2};
        logic [8:0] exp_strb  [3] = '{S_IREQ | S_PCWE, 9'h0, 9'h0};
        instr    = I_LW;
        imem_ack = 1'b1;
        dmem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (stage !== exp_stage[c] || strb !== exp_strb[c]) begin
                n_fail++; $display("FAIL midmem_pre c%0d: stage %0d strobes %b want %0d/%b",
                                   c, stage, strb, exp_stage[c], exp_strb[c]);
            end
            @(posedge clk);
            #1;
        end
        #1;
        n_checks++;
        if (stage !== 3'd3 || strb !== S_DREQ) begin
            n_fail++; $display("FAIL midmem_in_mem: stage %0d strobes %b want 3/%b", stage, strb, S_DREQ);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dmem_req !== 1'b0 || strb !== 9'h0 || stage !== 3'd0) begin
            n_fail++; $display("FAIL midmem_drop: dmem_req %b strobes %b stage %0d want 0/0/0",
                               dmem_req, strb, stage);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL midmem_no_req_in_reset: got %b want 0", imem_req);
        end
        instr = I_HALT;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b1) begin
            n_fail++; $display("FAIL midmem_first_req: got %b want 1", imem_req);
        end
    endtask

    task automatic test_halt();
        logic [2:0] exp_stage [5] = '{3'd0, 3'd1, 3'd6, 3'd6, 3'd6};
        logic [8:0] exp_strb  [5] = '{S_IREQ | S_PCWE, 9'h0, S_HALT, S_HALT, S_HALT};
        instr    = I_HALT;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (stage !== exp_stage[c]) begin
                n_fail++; $display("FAIL halt_stage c%0d: got %0d want %0d", c, stage, exp_stage[c]);
            end
            n_checks++;
            if (strb !== exp_strb[c]) begin
                n_fail++; $display("FAIL halt_strobes c%0d: got %b want %b", c, strb, exp_strb[c]);
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (ir !== I_HALT) begin
            n_fail++; $display("FAIL halt_ir: got %h want %h", ir, I_HALT);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw();
        test_sw_beq();
        test_trap();
        test_reset_mid_mem();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter INSTR_W, default 32, instruction width.
REQ-002 SHALL have parameter OPCODE_W, default 6, opcode width, taken from ir[INSTR_W-1 -: OPCODE_W].
REQ-003 SHALL have parameter CNT_W, default 32, performance-counter width.
REQ-004 SHALL have ports, in this order:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch complete; instr valid this cycle.
- instr  in  INSTR_W  fetched instruction.
- dmem_req  out  1  data access request.
- dmem_we  out  1  data access is a store.
- dmem_ack  in  1  data access complete.
- ir  out  INSTR_W  latched instruction register.
- stage  out  3  current stage encoding.
- pc_we  out  1  one-cycle PC+4 update strobe.
- rf_we  out  1  one-cycle register-file write strobe.
- br_eval  out  1  one-cycle branch-evaluate strobe.
- retire  out  1  one-cycle instruction-complete strobe.
- trap  out  1  illegal opcode seen; sticky.
- halted  out  1  HALT executed; sticky.
- retire_cnt  out  CNT_W  retired instructions (PERF_CNT_EN only).
- stall_cnt  out  CNT_W  handshake wait cycles (PERF_CNT_EN only).

Function
REQ-005 SHALL implement states IFETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5, HALTED=6; stage equals the state.
REQ-006 SHALL decode opcodes ADD=0x00, BEQ=0x04, LW=0x23, SW=0x2B, HALT=0x3F; every other opcode is illegal.
REQ-007 IFETCH SHALL assert imem_req; ack sampled in the same cycle counts; on ack latch instr into ir, pulse pc_we, go to DECODE; otherwise stay.
REQ-008 DECODE SHALL last 1 cycle: illegal -> TRAP; HALT -> HALTED; all others -> EXECUTE.
REQ-009 EXECUTE SHALL last 1 cycle: ADD -> WRITEBACK; LW/SW -> MEMORY; BEQ pulses br_eval and retire and goes to IFETCH.
REQ-010 MEMORY SHALL assert dmem_req (dmem_we=1 for SW only) until dmem_ack: LW -> WRITEBACK; SW pulses retire and goes to IFETCH.
REQ-011 WRITEBACK SHALL pulse rf_we and retire for 1 cycle, then go to IFETCH.
REQ-012 Minimum latency with zero-wait acks SHALL be BEQ 3, ADD 4, SW 4, LW 5 cycles, IFETCH entry to the next IFETCH.
REQ-013 imem_ack outside IFETCH and dmem_ack outside MEMORY SHALL be ignored.
REQ-014 TRAP and HALTED SHALL be terminal until reset; trap/halted SHALL be high in those states only; no request or strobe is asserted there.
REQ-015 ir SHALL change only on IFETCH ack.

Reset
REQ-016 rst_n low SHALL immediately force state IFETCH, ir=0, and every output, including imem_req and the counters, to 0.
REQ-017 Reset mid-handshake SHALL drop imem_req/dmem_req in the same cycle; the first fetch request SHALL be in the first cycle after rst_n rises.

Configuration
REQ-018 With PERF_CNT_EN defined, retire_cnt SHALL increment on each retire, and stall_cnt SHALL increment each IFETCH/MEMORY cycle without its ack; both saturate at all-ones.
REQ-019 Without PERF_CNT_EN, the retire_cnt and stall_cnt ports SHALL be tied to 0 and the counter logic SHALL be absent.

Structure
REQ-020 The package cpu_pkg SHALL hold the stage encodings and opcode constants.
REQ-021 A combinational sub-module op_decode SHALL map opcode to {is_add, is_beq, is_lw, is_sw, is_halt, illegal}.

Verification
REQ-022 ADD 0x00000000 with acks tied high -> stage 0,1,2,4,0; pc_we in cycle 1; rf_we and retire in cycle 4; 4 cycles total.
REQ-023 LW (opcode 0x23), dmem_ack held low 3 cycles -> dmem_req for 4 cycles, dmem_we=0, then WRITEBACK; stall_cnt=3 with PERF_CNT_EN.
REQ-024 SW (0x2B) then BEQ (0x04) -> SW: dmem_we=1, retire in MEMORY; BEQ: br_eval and retire in EXECUTE; retire_cnt=2.
REQ-025 Opcode 0x01 -> TRAP, trap=1 persists, no imem_req for 10 cycles; reset clears it.
REQ-026 rst_n dropped mid-MEMORY with dmem_req=1 -> dmem_req=0 in the same cycle; imem_req=1 in the first cycle after release; HALT (0x3F) -> halted=1.
